// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants, state type and helpers for the HI/LO multiply/divide controller.
`ifndef MULDIV_DEFINES
`define MULDIV_DEFINES
`define MD_ST_IDLE     2'd0
`define MD_ST_MUL_BUSY 2'd1
`define MD_ST_DIV_BUSY 2'd2
`define MD_ST_DONE     2'd3
`define MD_DIV_ITERS   32
`define MD_MUL_LAT     2
`endif

package muldiv_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE     = `MD_ST_IDLE,
    MUL_BUSY = `MD_ST_MUL_BUSY,
    DIV_BUSY = `MD_ST_DIV_BUSY,
    DONE     = `MD_ST_DONE
  } md_state_e;

  localparam int DIV_ITERS = `MD_DIV_ITERS;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn & v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// One restoring radix-2 step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module div_iter (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvs,
  output logic [31:0] rem_n,
  output logic [31:0] quo_n
);
  logic [32:0] sh, diff;

  assign sh    = {rem, quo[31]};
  assign diff  = sh - {1'b0, dvs};
  // rem < dvs keeps sh below 2*dvs, so bit 32 of diff is a clean borrow flag
  assign rem_n = diff[32] ? sh[31:0] : diff[31:0];
  assign quo_n = {quo[30:0], ~diff[32]};
endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage multiply/divide controller: pipelined 33x33 multiply, 32-step restoring
// divide, pipeline stall and one-cycle HI/LO write pulse.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = `MD_MUL_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ismult,
  input  logic        signedmult,
  input  logic        isdiv,
  input  logic        signeddiv,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo
);
  localparam logic [4:0] MUL_LAST = 5'(MUL_LAT >= 2 ? MUL_LAT - 2 : 0);
  localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

  md_state_e   state;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, dvs, rem_n, quo_n;
  logic        neg_q, neg_r;
  logic        accept, take_mul, take_div;
  logic [63:0] a_ext, b_ext, prod_in, mul_out;

  assign accept   = (state == IDLE) & (ismult | isdiv) & ~flush;
  assign take_mul = accept & ismult;
  assign take_div = accept & ~ismult;

  assign stall        = ~rst & (accept | (~flush & ((state == MUL_BUSY) | (state == DIV_BUSY))));
  assign result_valid = ~rst & ~flush & (state == DONE);

  // 33-bit operands extended to 64; the low 64 product bits are exact either way
  assign a_ext   = {{32{signedmult & src_a[31]}}, src_a};
  assign b_ext   = {{32{signedmult & src_b[31]}}, src_b};
  assign prod_in = a_ext * b_ext;

  generate
    if (MUL_LAT == 1) begin : g_lat1
      assign mul_out = prod_in;
    end else begin : g_pipe
      logic [63:0] mp [MUL_LAT-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < MUL_LAT - 1; i++) mp[i] <= '0;
        end else begin
          if (take_mul) mp[0] <= prod_in;
          for (int i = 1; i < MUL_LAT - 1; i++) mp[i] <= mp[i-1];
        end
      end
      assign mul_out = mp[MUL_LAT-2];
    end
  endgenerate

  div_iter u_div_iter (
    .rem   (rem),
    .quo   (quo),
    .dvs   (dvs),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (take_mul) begin
            state <= (MUL_LAT == 1) ? DONE : MUL_BUSY;
            cnt   <= '0;
            if (MUL_LAT == 1) {result_hi, result_lo} <= mul_out;
          end else if (take_div) begin
            state <= DIV_BUSY;
            cnt   <= '0;
            rem   <= '0;
            quo   <= abs32(src_a, signeddiv);
            dvs   <= abs32(src_b, signeddiv);
            // zero divisor must leave the all-ones quotient unnegated
            neg_q <= signeddiv & (src_a[31] ^ src_b[31]) & (|src_b);
            neg_r <= signeddiv & src_a[31];
          end
        end
        MUL_BUSY: begin
          if (cnt == MUL_LAST) begin
            state                  <= DONE;
            {result_hi, result_lo} <= mul_out;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DIV_BUSY: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 5'd1;
          if (cnt == DIV_LAST) begin
            state     <= DONE;
            result_lo <= neg_q ? -quo_n : quo_n;
            result_hi <= neg_r ? -rem_n : rem_n;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
